sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-to-parallel receiver that sits directly downstream of the team's PISO transmitter. It samples a qualified serial bit stream, assembles WIDTH-bit words in the configured bit order, and presents each completed word on a single-entry valid/ready output buffer. Reception continues while the buffer waits to drain; an overrun flag reports words lost to back-pressure. Its defaults match the PISO's 8-bit, LSB-first output, so a PISO-to-sipo_rx loop returns the original parallel word.

## Interface
- WIDTH, 8: word width in bits; legal range is 2 or greater.
- LSB_FIRST, 1: 1 means the first received bit lands in bit 0; 0 means the first received bit lands in bit WIDTH-1.
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the clk rising edge.
- serial_in, input, 1: serial data bit.
- bit_valid, input, 1: serial_in is sampled only on cycles where this is 1.
- clear, input, 1: synchronous flush of the receive side (see Operation).
- out_ready, input, 1: the consumer accepts parallel_out.
- parallel_out, output, WIDTH: held word. It is stable while out_valid is 1 and out_ready is 0.
- out_valid, output, 1: the holding register contains an unread word.
- bit_count, output, clog2(WIDTH): number of bits collected in the current word.
- overrun, output, 1: sticky flag; set when a completed word is dropped.

## Operation
- **Reset** (rst_n=0 at a clock edge) sets:
  - parallel_out=0, out_valid=0, bit_count=0, overrun=0;
  - the shift register to 0.
- **Bit shifting** happens on each edge where bit_valid=1 and clear=0:
  - LSB_FIRST=1: sr <= {serial_in, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], serial_in}.
  - bit_count increments by 1 and wraps from WIDTH-1 to 0.
- **Word completion** is a cycle with bit_valid=1 and bit_count=WIDTH-1. The shifted value, including the current bit, is the completed word.
  - If out_valid=0, or out_valid=1 and out_ready=1 in that cycle: load the word into parallel_out and set out_valid=1.
  - Otherwise: drop the word, set overrun=1, and leave parallel_out and out_valid unchanged.
- **Drain**: when out_valid=1, out_ready=1, and no word completes in the same cycle, out_valid goes to 0. parallel_out keeps its last value.
- **clear=1** (has priority over bit_valid):
  - Zeroes the shift register and bit_count, and sets overrun=0.
  - Also sets out_valid=0, discarding any held word. parallel_out is not changed.
- **Gaps**: cycles with bit_valid=0 hold all receive state. There is no timeout.
- **Priority order**: rst_n, then clear, then word completion/drain, then bit shifting.

## Timing
- A bit is sampled on the same edge at which bit_valid=1. There is no input synchronizer; serial_in and bit_valid are synchronous to clk.
- Word latency: out_valid and parallel_out update on the edge that samples the last bit, so they are visible in the following cycle.
- Throughput: one bit per cycle; back-to-back words need no idle cycle.
- Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1. out_ready may be asserted at any time and has no effect when out_valid=0.
- Same-cycle completion and transfer: the old word is consumed, the new word is loaded, and out_valid stays 1 with no bubble.
- overrun stays set until reset or clear. Once set, later completions still load normally when the buffer is free.
- Reset or clear mid-word: the partial word is lost, and the next bit_valid starts a new word at bit_count=0.
- PISO pairing: the PISO updates serial_out one cycle after its shift strobe, so bit_valid must be that strobe delayed by one cycle.

## Test plan
- **Single word, LSB first**: with out_ready=1, drive bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles. Expect parallel_out=0xA5 and out_valid=1 for exactly one cycle after the last bit; bit_count reads 0 afterwards.
- **Bit order and gaps**: with LSB_FIRST=0, drive bits 1,0,1,0,0,1,0,1 with random idle cycles between them. Expect parallel_out=0xA5, and bit_count holds its value during the gaps.
- **Back-pressure and overrun**: with out_ready=0, send 0x3C and then 0xC3 back-to-back. Expect parallel_out=0x3C, overrun=1, and out_valid=1. Then raise out_ready=1: out_valid drops and overrun stays 1.
- **Simultaneous complete and drain**: while 0x11 is held, assert out_ready on the cycle that 0x22's last bit arrives. Expect a 0x11 transfer on that edge, parallel_out=0x22 next cycle, and out_valid continuously 1.
- **clear mid-word**: after 5 bits, pulse clear with bit_valid=1 on the same cycle, then send 0x5A. Expect bit_count=0 after the clear, out_valid=0, overrun=0, and then parallel_out=0x5A.
- **Reset mid-word**: after 3 bits, hold rst_n=0 for 1 cycle, then send 0xFF. Expect all outputs 0 after reset, then parallel_out=0xFF exactly 8 bits later.

Source files
------------

// File: rtl/sipo_rx.sv
// sipo_rx: serial-to-parallel receiver with a single-entry valid/ready output buffer
// and a sticky overrun flag for words dropped under back-pressure.
module sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     serial_in,
  input  logic                     bit_valid,
  input  logic                     clear,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overrun
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr_q, sr_d, po_q, po_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d, ovr_q, ovr_d, done, load, drain;
  always_comb begin
    shifted = LSB_FIRST ? {serial_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], serial_in};
    done    = bit_valid && cnt_q == CW'(WIDTH - 1);
    // a completing word may replace a held word only if that word leaves this same cycle
    load    = done && (!valid_q || out_ready);
    drain   = valid_q && out_ready && !done;
    sr_d    = clear ? '0 : bit_valid ? shifted : sr_q;
    cnt_d   = (clear || done) ? '0 : bit_valid ? cnt_q + 1'b1 : cnt_q;
    po_d    = (!clear && load) ? shifted : po_q;
    valid_d = clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid_q;
    ovr_d   = clear ? 1'b0 : (done && !load) ? 1'b1 : ovr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q    <= '0;
      po_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      po_q    <= po_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign parallel_out = po_q;
  assign out_valid    = valid_q;
  assign bit_count    = cnt_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: LSB-first and MSB-first receivers share one stimulus stream; a word-level
// model predicts transfers into scoreboard queues that a negedge monitor drains.
module tb_sipo_rx;
  logic       clk = 1'b0;
  logic       rst_n, serial_in, bit_valid, clear, out_ready;
  logic [7:0] po0, po1;
  logic       v0, v1, ov0, ov1;
  logic [2:0] bc0, bc1;
  int         errors = 0, checks = 0;
  bit         mon_en = 1'b0;
  bit         bq[$];
  bit         m_held = 1'b0, m_ov = 1'b0;
  logic [7:0] q0[$], q1[$];

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid), .clear(clear),
    .out_ready(out_ready), .parallel_out(po0), .out_valid(v0), .bit_count(bc0), .overrun(ov0));
  sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid), .clear(clear),
    .out_ready(out_ready), .parallel_out(po1), .out_valid(v1), .bit_count(bc1), .overrun(ov1));

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Word-level reference: bits collect in a list; a full list becomes a word.
  task automatic model_step(input bit sin, input bit bv, input bit clr, input bit rdy, input bit rstn);
    logic [7:0] w0, w1;
    if (!rstn || clr) begin
      if (m_held && !rdy) begin
        void'(q0.pop_back());
        void'(q1.pop_back());
      end
      m_held = 0;
      m_ov = 0;
      bq.delete();
    end else if (bv) begin
      bq.push_back(sin);
      if (bq.size() == 8) begin
        w0 = 0;
        w1 = 0;
        for (int i = 0; i < 8; i++) begin
          w0 = w0 | (8'(bq[i]) << i);
          w1 = w1 | (8'(bq[i]) << (7 - i));
        end
        bq.delete();
        if (!m_held || rdy) begin
          q0.push_back(w0);
          q1.push_back(w1);
          m_held = 1;
        end else m_ov = 1;
      end else if (m_held && rdy) m_held = 0;
    end else if (m_held && rdy) m_held = 0;
  endtask

  task automatic drive(input bit sin, input bit bv, input bit clr, input bit rdy, input bit rstn);
    serial_in = sin;
    bit_valid = bv;
    clear = clr;
    out_ready = rdy;
    rst_n = rstn;
    @(posedge clk);
    model_step(sin, bv, clr, rdy, rstn);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input bit rdy, input bit rdy_last);
    for (int i = 0; i < 8; i++) drive(w[i], 1, 0, (i == 7) ? rdy_last : rdy, 1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("bit_count0", int'(bc0), bq.size());
      chk("bit_count1", int'(bc1), bq.size());
      chk("overrun0", int'(ov0), int'(m_ov));
      chk("overrun1", int'(ov1), int'(m_ov));
      chk("out_valid0", int'(v0), int'(m_held));
      chk("out_valid1", int'(v1), int'(m_held));
      if (v0 && out_ready) begin
        if (q0.size() == 0) chk("xfer0_unexpected", 1, 0);
        else chk("xfer0", int'(po0), int'(q0.pop_front()));
      end
      if (v1 && out_ready) begin
        if (q1.size() == 0) chk("xfer1_unexpected", 1, 0);
        else chk("xfer1", int'(po1), int'(q1.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] a5 = 8'hA5;
    int cnt;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    mon_en = 1;
    chk("rst_po0", int'(po0), 0);
    chk("rst_valid0", int'(v0), 0);
    chk("rst_bc0", int'(bc0), 0);
    chk("rst_ov0", int'(ov0), 0);
    // single word, LSB first
    send(8'hA5, 1, 1);
    chk("single_po0", int'(po0), 8'hA5);
    chk("single_valid0", int'(v0), 1);
    chk("single_bc0", int'(bc0), 0);
    drive(0, 0, 0, 1, 1);
    chk("single_valid_drop", int'(v0), 0);
    // MSB first with idle gaps
    cnt = 0;
    for (int i = 7; i >= 0; i--) begin
      drive(a5[i], 1, 0, 1, 1);
      cnt = (cnt + 1) % 8;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        drive(1, 0, 0, 1, 1);
        chk("gap_bc1_hold", int'(bc1), cnt);
      end
    end
    chk("gap_po1", int'(po1), 8'hA5);
    drive(0, 0, 1, 1, 1);
    // back-pressure and overrun
    send(8'h3C, 0, 0);
    send(8'hC3, 0, 0);
    chk("bp_po0", int'(po0), 8'h3C);
    chk("bp_ov0", int'(ov0), 1);
    chk("bp_valid0", int'(v0), 1);
    drive(0, 0, 0, 1, 1);
    chk("bp_drain_valid0", int'(v0), 0);
    chk("bp_ov_sticky", int'(ov0), 1);
    // clear mid-word with bit_valid on the same cycle
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 1);
    drive(1, 1, 1, 1, 1);
    chk("clr_bc0", int'(bc0), 0);
    chk("clr_valid0", int'(v0), 0);
    chk("clr_ov0", int'(ov0), 0);
    send(8'h5A, 1, 1);
    chk("clr_po0", int'(po0), 8'h5A);
    drive(0, 0, 1, 1, 1);
    // simultaneous completion and drain
    send(8'h11, 0, 0);
    send(8'h22, 0, 1);
    chk("simul_valid0", int'(v0), 1);
    chk("simul_po0", int'(po0), 8'h22);
    chk("simul_ov0", int'(ov0), 0);
    drive(0, 0, 0, 1, 1);
    // reset mid-word
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    chk("mrst_po0", int'(po0), 0);
    chk("mrst_po1", int'(po1), 0);
    chk("mrst_valid0", int'(v0), 0);
    chk("mrst_bc0", int'(bc0), 0);
    for (int i = 0; i < 7; i++) drive(1, 1, 0, 1, 1);
    chk("mrst_valid_early", int'(v0), 0);
    drive(1, 1, 0, 1, 1);
    chk("mrst_po0_ff", int'(po0), 8'hFF);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1);
    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
